// File: rtl/branch_resolve_predict_unit.sv
// branch_resolve_predict_unit
// Resolves conditional branches, JAL and JALR in EX against the prediction
// made at fetch, and raises a registered one-cycle flush plus redirect PC
// when they disagree.
// Optional feature macro: BRANCH_PREDICT_EN. When it is defined, the unit
// contains a direct-mapped BTB with saturating counters. When it is
// undefined, nothing is predicted and every taken control transfer flushes.
module branch_resolve_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [1:0]      branch_jump_signal,
  input  logic [2:0]      func_3,
  input  logic            zero_signal,
  input  logic            sign_bit_signal,
  input  logic            sltu_bit_signal,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            branch_jump_mux_signal
);

  localparam logic [1:0] BJ_NONE   = 2'b00;
  localparam logic [1:0] BJ_BRANCH = 2'b01;
  localparam logic [1:0] BJ_JALR   = 2'b11;

  logic            resolve;
  logic            cond_taken;
  logic            actual_taken;
  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;
  logic            mispredict;

  // Instructions arriving while a flush is in progress are on the wrong path.
  assign resolve = ex_valid && !flush && (branch_jump_signal != BJ_NONE);

  // Evaluate the branch condition from the ALU compare flags.
  always_comb begin
    // NOTE: a default assignment before the case keeps this purely combinational (no latch).
    cond_taken = 1'b0;
    case (func_3)
      3'b000:  cond_taken = zero_signal;
      3'b001:  cond_taken = !zero_signal;
      3'b100:  cond_taken = sign_bit_signal;
      3'b101:  cond_taken = !sign_bit_signal;
      3'b110:  cond_taken = sltu_bit_signal;
      3'b111:  cond_taken = !sltu_bit_signal;
      default: cond_taken = 1'b0;
    endcase
  end

  assign actual_taken = (branch_jump_signal == BJ_BRANCH) ? cond_taken : 1'b1;
  assign seq_target   = ex_pc + ex_imm;
  assign jalr_target  = {ex_alu_result[XLEN-1:1], 1'b0};
  assign target       = (branch_jump_signal == BJ_JALR) ? jalr_target : seq_target;
  assign fall_through = ex_pc + XLEN'(4);

`ifdef BRANCH_PREDICT_EN
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};

  logic                btb_valid   [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag     [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target  [BTB_ENTRIES];
  logic                btb_is_jump [BTB_ENTRIES];
  logic [CTR_BITS-1:0] btb_ctr     [BTB_ENTRIES];

  logic [IDX-1:0]      if_idx;
  logic [TAG_W-1:0]    if_tag;
  logic                if_hit;
  logic [IDX-1:0]      ex_idx;
  logic [TAG_W-1:0]    ex_tag;
  logic                ex_hit;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic                btb_we;
  logic                unused_bits;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[XLEN-1:IDX+2];
  assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

  assign pred_taken  = if_hit && (btb_is_jump[if_idx] || btb_ctr[if_idx][CTR_BITS-1]);
  assign pred_target = pred_taken ? btb_target[if_idx] : '0;

  assign ex_idx  = ex_pc[IDX+1:2];
  assign ex_tag  = ex_pc[XLEN-1:IDX+2];
  assign ex_hit  = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  assign ctr_cur = btb_ctr[ex_idx];

  // A not-taken branch that misses the BTB must not claim an entry.
  assign btb_we = resolve && (ex_hit || actual_taken);

  // Next counter value: saturating step on a hit, weak initial state on allocate.
  always_comb begin
    ctr_next = actual_taken ? CTR_WEAK_T : CTR_WEAK_NT;
    if (ex_hit) begin
      if (actual_taken) ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_BITS'(1);
      else              ctr_next = (ctr_cur == '0)      ? ctr_cur : ctr_cur - CTR_BITS'(1);
    end
  end

  // Valid bits: cleared by reset, set when an entry is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      btb_valid[ex_idx] <= 1'b1;
    end
  end

  // Entry payload: written on resolution, never reset.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays have no reset; an entry is only trusted while its valid bit is set.
    if (btb_we && !reset) begin
      btb_tag[ex_idx]     <= ex_tag;
      btb_target[ex_idx]  <= target;
      btb_is_jump[ex_idx] <= (branch_jump_signal != BJ_BRANCH);
      btb_ctr[ex_idx]     <= ctr_next;
    end
  end

  assign mispredict = resolve &&
                      ((actual_taken != ex_pred_taken) ||
                       (actual_taken && (target != ex_pred_target)));

  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_alu_result[0]};
`else
  localparam int UNUSED_CFG = BTB_ENTRIES + CTR_BITS;

  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;

  // Without a predictor, fetch always falls through, so any taken transfer is a miss.
  assign mispredict = resolve && actual_taken;

  assign unused_bits = ^{if_pc, ex_pred_taken, ex_pred_target, ex_alu_result[0]};
`endif

  // Registered flush pulse and redirect PC; the redirect PC holds between mispredicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= actual_taken ? target : fall_through;
    end
  end

  assign branch_jump_mux_signal = flush;

endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
// Directed bench for branch_resolve_predict_unit. It handles both builds
// (BRANCH_PREDICT_EN defined or not). Expected flush/redirect results are
// queued when a resolution is driven and popped after the next clock edge.
module tb_branch_resolve_predict_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_result;
  logic [1:0]  branch_jump_signal;
  logic [2:0]  func_3;
  logic        zero_signal;
  logic        sign_bit_signal;
  logic        sltu_bit_signal;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        branch_jump_mux_signal;

  branch_resolve_predict_unit dut (
    .clk                    (clk),
    .reset                  (reset),
    .if_pc                  (if_pc),
    .pred_taken             (pred_taken),
    .pred_target            (pred_target),
    .ex_valid               (ex_valid),
    .ex_pc                  (ex_pc),
    .ex_imm                 (ex_imm),
    .ex_alu_result          (ex_alu_result),
    .branch_jump_signal     (branch_jump_signal),
    .func_3                 (func_3),
    .zero_signal            (zero_signal),
    .sign_bit_signal        (sign_bit_signal),
    .sltu_bit_signal        (sltu_bit_signal),
    .ex_pred_taken          (ex_pred_taken),
    .ex_pred_target         (ex_pred_target),
    .flush                  (flush),
    .redirect_pc            (redirect_pc),
    .branch_jump_mux_signal (branch_jump_mux_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        flush;
    logic [31:0] redirect;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_redirect = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_model(input logic [2:0] f3, input logic z, input logic s, input logic u);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      3'b110:  return u;
      3'b111:  return !u;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one resolution and queue its expected registered result.
  task automatic drive_res(input string tag, input logic [1:0] sig, input logic [2:0] f3,
                           input logic z, input logic s, input logic u,
                           input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                           input logic pt, input logic [31:0] ptgt, output logic mis);
    logic        taken;
    logic [31:0] tgt;
    exp_t        e;
    ex_valid = 1'b1; branch_jump_signal = sig; func_3 = f3;
    zero_signal = z; sign_bit_signal = s; sltu_bit_signal = u;
    ex_pc = pc; ex_imm = imm; ex_alu_result = alu;
    ex_pred_taken = pt; ex_pred_target = ptgt;
    taken = (sig == 2'b01) ? cond_model(f3, z, s, u) : 1'b1;
    tgt   = (sig == 2'b11) ? {alu[31:1], 1'b0} : pc + imm;
    mis   = PE ? ((taken != pt) || (taken && (tgt != ptgt))) : taken;
    if (mis) m_redirect = taken ? tgt : pc + 32'd4;
    e.tag = tag; e.flush = mis; e.redirect = m_redirect;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".flush"},    {31'b0, flush},                  {31'b0, e.flush});
      check({e.tag, ".mux"},      {31'b0, branch_jump_mux_signal}, {31'b0, e.flush});
      check({e.tag, ".redirect"}, redirect_pc,                     e.redirect);
    end
  endtask

  task automatic idle(input string tag);
    exp_t e;
    e.tag = tag; e.flush = 1'b0; e.redirect = m_redirect;
    sb.push_back(e);
    tick();
    check_out();
  endtask

  task automatic resolve_one(input string tag, input logic [1:0] sig, input logic [2:0] f3,
                             input logic z, input logic s, input logic u,
                             input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                             input logic pt, input logic [31:0] ptgt);
    logic mis;
    drive_res(tag, sig, f3, z, s, u, pc, imm, alu, pt, ptgt, mis);
    tick();
    ex_valid = 1'b0;
    check_out();
    if (mis) idle({tag, ".pulse_end"});
  endtask

  // Fetch lookup; values given are those of the predicting build.
  task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, ".pred_taken"},  {31'b0, pred_taken}, PE ? {31'b0, t} : 32'h0);
    check({tag, ".pred_target"}, pred_target,         PE ? tgt : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mis;
    reset = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0;
    ex_alu_result = 32'h0; branch_jump_signal = 2'b00; func_3 = 3'b000;
    zero_signal = 1'b0; sign_bit_signal = 1'b0; sltu_bit_signal = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;

    // Reset for one cycle, then check cleared state.
    tick();
    reset = 1'b0;
    check("rst.flush", {31'b0, flush}, 32'h0);
    check("rst.redirect", redirect_pc, 32'h0);
    look("rst.look", 32'h100, 1'b0, 32'h0);

    // First beq at 0x100, taken, predicted not taken. The lookup in the update cycle sees the old entry.
    drive_res("beq_first", 2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, mis);
    look("same_edge", 32'h100, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    check_out();
    if (mis) idle("beq_first.pulse_end");
    look("alloc", 32'h100, 1'b1, 32'h120);

    // Three correctly predicted taken repeats, which saturate the counter at 3.
    for (int i = 0; i < 3; i++)
      resolve_one($sformatf("beq_rep%0d", i), 2'b01, 3'b000, 1'b1, 1'b0, 1'b0,
                  32'h100, 32'h20, 32'h0, PE, 32'h120);
    look("saturated", 32'h100, 1'b1, 32'h120);

    // Two not-taken resolutions: counter 3 -> 2 -> 1.
    resolve_one("bne_nt1", 2'b01, 3'b001, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, PE, 32'h120);
    look("after_nt1", 32'h100, 1'b1, 32'h120);
    resolve_one("bne_nt2", 2'b01, 3'b001, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, PE, 32'h120);
    look("after_nt2", 32'h100, 1'b0, 32'h0);

    // JALR: bit 0 of the ALU result is cleared.
    resolve_one("jalr_ok",  2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h305, 1'b1, 32'h304);
    resolve_one("jalr_bad", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h305, 1'b1, 32'h300);
    look("jalr_btb", 32'h200, 1'b1, 32'h304);

    // A valid instruction in the flush cycle is ignored.
    drive_res("sup_a", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'h310, 32'h40, 32'h0, 1'b0, 32'h0, mis);
    tick();
    check_out();
    ex_valid = 1'b1; branch_jump_signal = 2'b10; ex_pc = 32'h420; ex_imm = 32'h8;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    idle("sup_b");
    ex_valid = 1'b0;
    idle("sup_after");
    look("sup_a_btb", 32'h310, 1'b1, 32'h350);
    look("sup_b_btb", 32'h420, 1'b0, 32'h0);

    // Reset while a mispredicting JAL is in EX: the resolution is discarded and the BTB is cleared.
    ex_valid = 1'b1; branch_jump_signal = 2'b10; ex_pc = 32'h900; ex_imm = 32'h4;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex_valid = 1'b0;
    m_redirect = 32'h0;
    check("rst2.flush", {31'b0, flush}, 32'h0);
    check("rst2.redirect", redirect_pc, 32'h0);
    look("rst2.sup_a", 32'h310, 1'b0, 32'h0);
    look("rst2.jal", 32'h900, 1'b0, 32'h0);

    // Back-to-back resolutions without mispredicts.
    drive_res("b2b_1", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h600, 32'h40, 32'h0, 1'b0, 32'h0, mis);
    tick();
    check_out();
    drive_res("b2b_2", 2'b01, 3'b101, 1'b0, 1'b1, 1'b0, 32'h604, 32'h40, 32'h0, 1'b0, 32'h0, mis);
    tick();
    ex_valid = 1'b0;
    check_out();

    // Sweep of every condition code against one-hot flag patterns.
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 3; p++) begin
        resolve_one($sformatf("cond_f%0d_p%0d", f, p), 2'b01, 3'(f),
                    (p == 0), (p == 1), (p == 2),
                    32'h1000 + 32'(f * 16 + p * 4), 32'h100, 32'h0, 1'b0, 32'h0);
      end
    end

    // JAL whose target wraps around the address space.
    resolve_one("jal_wrap", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 32'h0);
    check("jal_wrap.value", m_redirect, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
